load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the pipelined core's word-only data memory port (mem_read/mem_write/addr/wdata/rdata).
//  Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, with sign/zero extension on loads.
//  Sub-word stores use read-modify-write. Stalls the pipeline until the access completes.
// PARAMETERS
//  MEM_BYTES  8192  size of the data memory in bytes; used only by the bounds check
// PORTS
//  clk         in   1   core clock; all state changes on posedge
//  rst         in   1   synchronous reset, active-high
//  req_valid   in   1   MEM stage holds a load/store; held stable with the other req_* signals while stall=1
//  req_write   in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3: size/sign of the access
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (bits [7:0] for SB, [15:0] for SH)
//  stall       out  1   hold the pipeline this cycle
//  resp_valid  out  1   1-cycle pulse: access finished; resp_rdata/fault are valid
//  resp_rdata  out  32  extended load data; 0 for stores and faults
//  fault       out  1   with resp_valid: misaligned access, illegal funct3 or out-of-bounds address
//  mem_read    out  1   memory read enable
//  mem_write   out  1   memory write enable, sampled by memory on posedge
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_wdata   out  32  full word to write
//  mem_rdata   in   32  combinational read data; 0 when mem_read=0
// BEHAVIOUR
//  FSM states: IDLE, RMW_WR, RESP. Reset -> IDLE, and clears the merge buffer and the resp registers.
//  After reset all outputs are 0.
//  Invariant: mem_read and mem_write are never both 1, so the memory's write-forward path is never used.
//  IDLE with req_valid=0:
//   - all outputs 0.
//  IDLE with req_valid=1 (accept cycle, stall=1):
//   - fault check first (illegal funct3, misaligned, out of bounds): no memory enable; next state RESP with fault=1.
//   - load: mem_read=1; extend mem_rdata and register it into resp_rdata; next state RESP.
//   - SW: mem_write=1, mem_wdata=req_wdata; next state RESP.
//   - SB/SH: mem_read=1; capture mem_rdata into the merge buffer; next state RMW_WR.
//  RMW_WR (stall=1):
//   - mem_write=1; mem_wdata = merge buffer with the byte/half lane replaced.
//   - lane: byte = addr[1:0], half = addr[1]. Next state RESP.
//  RESP (stall=0):
//   - resp_valid=1; the pipeline advances at this edge; next state IDLE unconditionally.
//   - So a new request sees one idle cycle. resp_valid is 0 in every other state.
//  Latency in cycles, accept cycle through RESP:
//   - load / SW / fault: 2
//   - SB / SH: 3
//  Load extension:
//   - byte lane = addr[1:0], half lane = addr[1].
//   - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: whole word.
//  Alignment: halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
//  Illegal funct3:
//   - loads: 3'b011, 3'b110, 3'b111.
//   - stores: anything above 3'b010.
//  Reset in any state: next state IDLE; no mem_write issues on the cycle after reset. Reset in IDLE-accept or RMW_WR drops the pending write.
//  req_* changing while stall=1 is a protocol violation; the design does not check it.
// CONFIGURATION
//  LSU_BOUNDS_CHECK_EN defined:
//   - req_addr >= MEM_BYTES faults, with no memory enable.
//  LSU_BOUNDS_CHECK_EN undefined:
//   - no check; the memory ignores the upper address bits, so the address aliases (wraps) modulo memory size.
//   - fault then covers misaligned access and illegal funct3 only.
// TESTING  (mem[0x100]=0x8899AABB, mem[0x000]=0x00000013 preloaded)
//  LW 0x100 -> stall=1 for 1 cycle; then resp_valid=1 with resp_rdata=0x8899AABB, fault=0; next cycle IDLE.
//  LB 0x103 -> 0xFFFFFF88. LBU 0x103 -> 0x00000088. LH 0x102 -> 0xFFFF8899. LHU 0x100 -> 0x0000AABB.
//  SB 0x101, wdata=0x12345677 -> 1 read cycle, then 1 write cycle of 0x889977BB, then resp_valid; 3 cycles total.
//   Follow with LW 0x100 -> 0x889977BB.
//  SH 0x101 -> fault=1 with resp_valid in cycle 2; mem_read=mem_write=0 throughout; resp_rdata=0. Same result for funct3=3'b111 load.
//  SH 0x102: assert rst in the accept cycle -> no mem_write ever issues; mem[0x100] unchanged; all outputs 0 next cycle.
//  LW 0x2000 -> with LSU_BOUNDS_CHECK_EN: fault=1, no mem_read; without it: resp_rdata=0x00000013 (aliases to word 0).

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word RV32I accesses over a word-only data port, RMW for sub-word stores.
// Optional LSU_BOUNDS_CHECK_EN faults addresses at or above MEM_BYTES instead of letting them alias.
module load_store_unit #(
    parameter int MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

    state_t      state, state_next;
    logic [31:0] merge_buf, merge_next;
    logic [31:0] resp_rdata_q, rdata_next;
    logic        fault_q, fault_next;
    logic        rst_hold;

    logic        is_byte, is_half, is_word;
    logic        illegal_f3, misaligned, out_of_bounds, req_fault;
    logic [31:0] word_addr, lane_word, load_ext, merged;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign is_byte   = (req_funct3[1:0] == 2'b00);
    assign is_half   = (req_funct3[1:0] == 2'b01);
    assign is_word   = (req_funct3[1:0] == 2'b10);
    assign word_addr = {req_addr[31:2], 2'b00};

    assign illegal_f3 = req_write ? (req_funct3 > 3'b010)
                                  : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_bounds = (req_addr >= 32'(MEM_BYTES));
`else
    // Without the check the memory simply aliases high addresses; MEM_BYTES is not needed.
    logic unused_mem_bytes;
    assign unused_mem_bytes = (MEM_BYTES != 0);
    assign out_of_bounds    = 1'b0;
`endif

    assign req_fault = illegal_f3 || misaligned || out_of_bounds;

    assign lane_word = mem_rdata >> {req_addr[1:0], 3'b000};
    assign byte_val  = lane_word[7:0];
    assign half_val  = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (req_funct3)
            3'b000:  load_ext = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_ext = {{16{half_val[15]}}, half_val};
            3'b100:  load_ext = {24'h0, byte_val};
            3'b101:  load_ext = {16'h0, half_val};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_buf;
        if (is_byte)
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        else if (req_addr[1])
            merged[31:16] = req_wdata[15:0];
        else
            merged[15:0] = req_wdata[15:0];
    end

    // rst_hold blocks acceptance for the cycle after reset so a held request cannot write then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            merge_buf    <= 32'h0;
            resp_rdata_q <= 32'h0;
            fault_q      <= 1'b0;
            rst_hold     <= 1'b1;
        end else begin
            state        <= state_next;
            merge_buf    <= merge_next;
            resp_rdata_q <= rdata_next;
            fault_q      <= fault_next;
            rst_hold     <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        merge_next = merge_buf;
        rdata_next = resp_rdata_q;
        fault_next = fault_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        fault      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid && !rst_hold) begin
                    stall      = 1'b1;
                    state_next = RESP;
                    rdata_next = 32'h0;
                    fault_next = 1'b0;
                    if (req_fault) begin
                        fault_next = 1'b1;
                    end else if (!req_write) begin
                        mem_read   = 1'b1;
                        mem_addr   = word_addr;
                        rdata_next = load_ext;
                    end else if (is_word) begin
                        mem_write = 1'b1;
                        mem_addr  = word_addr;
                        mem_wdata = req_wdata;
                    end else begin
                        mem_read   = 1'b1;
                        mem_addr   = word_addr;
                        merge_next = mem_rdata;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                stall      = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = word_addr;
                mem_wdata  = merged;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = resp_rdata_q;
                fault      = fault_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a word-addressed 8 KiB memory model.
// Expected results assume the memory preload below; LSU_BOUNDS_CHECK_EN selects the out-of-range expectation.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, fault, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(8192)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr[12:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[12:2]] <= mem_wdata;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                    input logic exp_fault, input int exp_lat,
                                    input int exp_reads, input int exp_writes);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        v.exp_reads = exp_reads; v.exp_writes = exp_writes;
        vecs.push_back(v);
    endfunction

    // Drives one request and follows it cycle by cycle until resp_valid or the cycle budget runs out.
    task automatic apply_stimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic [31:0] got_rdata, output logic got_fault,
                                  output int lat, output int reads, output int writes,
                                  output int stalls, output logic both, output logic timeout);
        lat = 0; reads = 0; writes = 0; stalls = 0; both = 1'b0; timeout = 1'b1;
        got_rdata = 32'h0; got_fault = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            lat++;
            if (mem_read) reads++;
            if (mem_write) writes++;
            if (stall) stalls++;
            if (mem_read && mem_write) both = 1'b1;
            if (resp_valid) begin
                got_rdata = resp_rdata;
                got_fault = fault;
                timeout   = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        f, both, tmo;
        int          lat, rd, wrc, stc, wr_seen;

        for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
        mem[11'h000] <= 32'h0000_0013;
        mem[11'h040] <= 32'h8899_AABB;
        mem[11'h7FF] <= 32'h1122_3344;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

        //        wr    f3      addr          wdata          exp_rdata      flt lat rd wr
        add_vec(1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8899_AABB, 0, 2, 1, 0); // LW
        add_vec(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'hFFFF_FF88, 0, 2, 1, 0); // LB
        add_vec(1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_0088, 0, 2, 1, 0); // LBU
        add_vec(1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_8899, 0, 2, 1, 0); // LH
        add_vec(1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_AABB, 0, 2, 1, 0); // LHU
        add_vec(1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FFBB, 0, 2, 1, 0); // LB lane 0
        add_vec(1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_00AA, 0, 2, 1, 0); // LBU lane 1
        add_vec(1'b1, 3'b000, 32'h0000_0101, 32'h1234_5677, 32'h0,         0, 3, 1, 1); // SB
        add_vec(1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8899_77BB, 0, 2, 1, 0); // LW after SB
        add_vec(1'b1, 3'b001, 32'h0000_0101, 32'h0000_FFFF, 32'h0,         1, 2, 0, 0); // SH misaligned
        add_vec(1'b0, 3'b111, 32'h0000_0100, 32'h0,         32'h0,         1, 2, 0, 0); // load f3=111
        add_vec(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1, 2, 0, 0); // load f3=011
        add_vec(1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         1, 2, 0, 0); // LW misaligned
        add_vec(1'b0, 3'b001, 32'h0000_0103, 32'h0,         32'h0,         1, 2, 0, 0); // LH misaligned
        add_vec(1'b1, 3'b011, 32'h0000_0104, 32'h0,         32'h0,         1, 2, 0, 0); // store f3=011
        add_vec(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 2, 0, 1); // SW
        add_vec(1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 0, 2, 1, 0);
        add_vec(1'b1, 3'b001, 32'h0000_0106, 32'h0000_CAFE, 32'h0,         0, 3, 1, 1); // SH upper
        add_vec(1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_BEEF, 0, 2, 1, 0);
        add_vec(1'b1, 3'b000, 32'h0000_0104, 32'h0000_0055, 32'h0,         0, 3, 1, 1); // SB lane 0
        add_vec(1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_BE55, 0, 2, 1, 0);
        add_vec(1'b0, 3'b001, 32'h0000_0106, 32'h0,         32'hFFFF_CAFE, 0, 2, 1, 0); // LH upper
        add_vec(1'b0, 3'b101, 32'h0000_0106, 32'h0,         32'h0000_CAFE, 0, 2, 1, 0); // LHU upper
        add_vec(1'b0, 3'b010, 32'h0000_1FFC, 32'h0,         32'h1122_3344, 0, 2, 1, 0); // last word
`ifdef LSU_BOUNDS_CHECK_EN
        add_vec(1'b0, 3'b010, 32'h0000_2000, 32'h0,         32'h0,         1, 2, 0, 0);
`else
        add_vec(1'b0, 3'b010, 32'h0000_2000, 32'h0,         32'h0000_0013, 0, 2, 1, 0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs",
                     {stall, resp_valid, fault, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata},
                     {5'b0, 96'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_outputs",
                     {stall, resp_valid, fault, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata},
                     {5'b0, 96'h0});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                           r, f, lat, rd, wrc, stc, both, tmo);
            check_output($sformatf("v%0d_timeout", i), {31'h0, tmo}, 32'h0);
            check_output($sformatf("v%0d_rdata", i), r, vecs[i].exp_rdata);
            check_output($sformatf("v%0d_fault", i), {31'h0, f}, {31'h0, vecs[i].exp_fault});
            check_output($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check_output($sformatf("v%0d_stall_cycles", i), stc, vecs[i].exp_lat - 1);
            check_output($sformatf("v%0d_reads", i), rd, vecs[i].exp_reads);
            check_output($sformatf("v%0d_writes", i), wrc, vecs[i].exp_writes);
            check_output($sformatf("v%0d_rw_overlap", i), {31'h0, both}, 32'h0);
        end

        // Reset asserted in the accept cycle of SH 0x102: the merge write must never happen.
        wr_seen = 0;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_0102; req_wdata = 32'h0000_FFFF;
        @(negedge clk);
        check_output("rst_accept_stall", {31'h0, stall}, 32'h1);
        if (mem_write) wr_seen++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_next_outputs",
                     {stall, resp_valid, fault, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata},
                     {5'b0, 96'h0});
        if (mem_write) wr_seen++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
        end
        check_output("rst_no_write", wr_seen, 0);
        apply_stimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, r, f, lat, rd, wrc, stc, both, tmo);
        check_output("rst_mem_unchanged", r, 32'h8899_77BB);
        check_output("rst_followup_fault", {31'h0, f}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
